// File: rtl/dmem_responder_pkg.sv
// Shared types for the data-memory responder: size encoding, FSM states,
// request snapshot and per-lane store placement.
package dmem_responder_pkg;

  localparam int NUM_LANES = 4;

  // 2'b10 is left unused so it can be flagged as an illegal size
  typedef enum logic [1:0] {
    BYTE      = 2'b00,
    HALF_WORD = 2'b01,
    WORD      = 2'b11
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } dmem_state_t;

  typedef struct packed {
    logic        write;
    mem_size_t   size;
    logic        zero_extend;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dmem_req_t;

  typedef struct packed {
    logic [NUM_LANES-1:0]      be;
    logic [NUM_LANES-1:0][7:0] data;
  } store_lanes_t;

  function automatic logic size_illegal(mem_size_t s);
    return s == mem_size_t'(2'b10);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Core-side load/store request/response bus of the data-memory responder.
interface dmem_responder_if;
  import dmem_responder_pkg::*;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  mem_size_t   req_size;
  logic        req_zero_extend;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;

  modport master (
    output req_valid, req_write, req_size, req_zero_extend, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error
  );

  modport slave (
    input  req_valid, req_write, req_size, req_zero_extend, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_error
  );

endinterface

// File: rtl/dmem_responder_lane_align.sv
// Lane steering between a RAM word and right-aligned core data: load
// extraction with sign/zero extension, and store byte enables/replication.
module dmem_lane_align
  import dmem_responder_pkg::*;
(
  input  logic [31:0]          rd_word,
  input  logic [1:0]           lane,
  input  mem_size_t            size,
  input  logic                 zero_extend,
  input  logic [31:0]          wdata,
  output logic [31:0]          load_data,
  output logic [NUM_LANES-1:0] byte_en,
  output logic [31:0]          wdata_lanes
);

  // Unknown sizes fall through to word handling; halfwords only look at lane[1]
  function automatic logic [31:0] extract_load(logic [31:0] w, logic [1:0] ln,
                                               mem_size_t sz, logic zx);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{ln, 3'b000} +: 8];
    h = ln[1] ? w[31:16] : w[15:0];
    case (sz)
      BYTE:      return {{24{b[7] & ~zx}}, b};
      HALF_WORD: return {{16{h[15] & ~zx}}, h};
      default:   return w;
    endcase
  endfunction

  function automatic store_lanes_t place_store(logic [31:0] d, logic [1:0] ln,
                                               mem_size_t sz);
    store_lanes_t s;
    case (sz)
      BYTE: begin
        s.be   = 4'b0001 << ln;
        s.data = {4{d[7:0]}};
      end
      HALF_WORD: begin
        s.be   = ln[1] ? 4'b1100 : 4'b0011;
        s.data = {2{d[15:0]}};
      end
      default: begin
        s.be   = '1;
        s.data = d;
      end
    endcase
    return s;
  endfunction

  store_lanes_t st;

  assign load_data   = extract_load(rd_word, lane, size, zero_extend);
  assign st          = place_store(wdata, lane, size);
  assign byte_en     = st.be;
  assign wdata_lanes = st.data;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one access at a time, WAIT_CYCLES wait states, then
// a one-cycle response. Define DMEM_ERR_CHECK_EN to reject misaligned,
// illegal-size and out-of-range accesses instead of wrapping/aligning them.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input logic             clk,
  input logic             rst,
  dmem_responder_if.slave bus
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  dmem_state_t          state, state_nxt;
  logic [3:0]           cnt;
  dmem_req_t            req_q, cur;
  logic [31:0]          mem [DEPTH];
  logic [31:0]          rdata_q;
  logic                 error_q;
  logic                 accept, commit, err;
  logic [AW-1:0]        idx;
  logic [31:0]          word_rd, load_data, wdata_lanes;
  logic [NUM_LANES-1:0] byte_en;

  assign accept = (state == IDLE) && bus.req_valid;

  // Live bus fields while idle so a zero-wait access commits on its acceptance edge
  always_comb begin
    cur = req_q;
    if (state == IDLE)
      cur = '{write: bus.req_write, size: bus.req_size, zero_extend: bus.req_zero_extend,
              addr: bus.req_addr, wdata: bus.req_wdata};
  end

  assign commit = (accept && (WAIT_CYCLES == 0)) || ((state == WAIT) && (cnt == 4'd0));
  assign idx     = cur.addr[AW+1:2];
  assign word_rd = mem[idx];

`ifdef DMEM_ERR_CHECK_EN
  assign err = size_illegal(cur.size)
             || ((cur.size == HALF_WORD) && cur.addr[0])
             || ((cur.size == WORD) && (|cur.addr[1:0]))
             || (|cur.addr[31:AW+2]);
`else
  logic addr_hi_unused;
  assign addr_hi_unused = ^cur.addr[31:AW+2];
  assign err            = 1'b0;
`endif

  dmem_lane_align u_align (
    .rd_word     (word_rd),
    .lane        (cur.addr[1:0]),
    .size        (cur.size),
    .zero_extend (cur.zero_extend),
    .wdata       (cur.wdata),
    .load_data   (load_data),
    .byte_en     (byte_en),
    .wdata_lanes (wdata_lanes)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.req_valid) state_nxt = (WAIT_CYCLES == 0) ? RESP : WAIT;
      WAIT:    if (cnt == 4'd0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = (state == IDLE);
    bus.rsp_valid = (state == RESP);
    bus.rsp_rdata = rdata_q;
    bus.rsp_error = error_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= 4'd0;
      req_q   <= '0;
      rdata_q <= '0;
      error_q <= 1'b0;
    end else begin
      if (accept) begin
        req_q <= cur;
        cnt   <= CNT_INIT;
      end else if ((state == WAIT) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      // Response data lives only for the RESP cycle
      if (commit) begin
        rdata_q <= (cur.write || err) ? 32'd0 : load_data;
        error_q <= err;
      end else if (state == RESP) begin
        rdata_q <= '0;
        error_q <= 1'b0;
      end
    end
  end

  // RAM is deliberately not reset
  always_ff @(posedge clk) begin
    if (commit && cur.write && !err)
      for (int i = 0; i < NUM_LANES; i++)
        if (byte_en[i]) mem[idx][8*i +: 8] <= wdata_lanes[8*i +: 8];
  end

endmodule
